// File: rtl/audio_ram_reader_if.sv
// ---------------------------------------------------------------------------
// audio_ram_reader_if
// Bundle of the two buses on the audio RAM reader:
//   - the RAM port-2 bus (address, chipselect, clken, write, writedata,
//     readdata), with a 1-cycle read latency from a registered address
//   - the frame stream towards the codec serializer (frame_data,
//     frame_valid, frame_ready)
// Modports:
//   master : the reader side; drives the RAM bus and the frame stream
//   slave  : the RAM + codec side; returns readdata and frame_ready
// ---------------------------------------------------------------------------
interface audio_ram_reader_if #(
  parameter int ADDR_W = 14
);
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_clken;
  logic              mem_write;
  logic [7:0]        mem_writedata;
  logic [7:0]        mem_readdata;
  logic [31:0]       frame_data;
  logic              frame_valid;
  logic              frame_ready;

  modport master (
    output mem_address, mem_chipselect, mem_clken, mem_write, mem_writedata,
    input  mem_readdata,
    output frame_data, frame_valid,
    input  frame_ready
  );

  modport slave (
    input  mem_address, mem_chipselect, mem_clken, mem_write, mem_writedata,
    output mem_readdata,
    input  frame_data, frame_valid,
    output frame_ready
  );
endinterface

// File: rtl/audio_ram_reader.sv
// ---------------------------------------------------------------------------
// audio_ram_reader
// Playback consumer on port 2 of the dual-port audio RAM. The CPU fills the
// RAM as a byte ring buffer; this block fetches four bytes per stereo frame,
// assembles {right, left} 16-bit little-endian PCM and hands it to the codec
// over valid/ready.
// Ports:
//   clk, reset_n      clock (shared with the RAM port) / async active-low reset
//   enable_i          playback enable
//   flush_i           1-cycle pulse: drop buffered data, rd_ptr := wr_ptr
//   wr_ptr_i          CPU byte write pointer (top bit = wrap bit)
//   rd_ptr_o          byte read pointer of the last accepted frame
//   fill_level_o      wr_ptr - rd_ptr, modulo 2**(ADDR_W+1)
//   underrun_o        1-cycle pulse on a starved codec request
//   underrun_count_o  saturating count of starved requests
//   bus               RAM port-2 bus and frame stream (master side)
// ---------------------------------------------------------------------------
module audio_ram_reader #(
  parameter int ADDR_W = 14,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable_i,
  input  logic                 flush_i,
  input  logic [ADDR_W:0]      wr_ptr_i,
  output logic [ADDR_W:0]      rd_ptr_o,
  output logic [ADDR_W:0]      fill_level_o,
  output logic                 underrun_o,
  output logic [CNT_W-1:0]     underrun_count_o,
  audio_ram_reader_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       frame_q, frame_d;
  logic [CNT_W-1:0]  ucnt_q, ucnt_d;

  logic [ADDR_W:0]   fill;
  logic              have_frame;
  logic              frame_valid;
  logic              accept;
  logic              starved;
  logic [ADDR_W-1:0] fetch_addr;

  // Pointers carry a wrap bit, so plain modular subtraction distinguishes
  // empty (0) from full (2**ADDR_W).
  assign fill       = wr_ptr_i - rd_ptr_q;
  assign have_frame = (fill >= (ADDR_W+1)'(4));
  assign accept     = frame_valid & bus.frame_ready;
  assign starved    = enable_i & bus.frame_ready & ~frame_valid & ~have_frame;
  // RAM depth is a power of two, so dropping the wrap bit wraps the address.
  assign fetch_addr = rd_ptr_q[ADDR_W-1:0] + ADDR_W'(k_q);

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic; flush overrides every other event
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable_i && have_frame) state_d = FETCH;
      FETCH:   if (k_q == 2'd3)            state_d = CAPTURE;
      CAPTURE:                             state_d = HOLD;
      HOLD:    if (bus.frame_ready)        state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  // FSM: outputs decoded from the current state
  always_comb begin
    bus.mem_chipselect = 1'b0;
    bus.mem_clken      = 1'b0;
    bus.mem_address    = addr_q;
    frame_valid        = 1'b0;
    case (state_q)
      FETCH: begin
        bus.mem_chipselect = 1'b1;
        bus.mem_clken      = 1'b1;
        bus.mem_address    = fetch_addr;
      end
      HOLD:    frame_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state: byte offset, address hold, byte assembly,
  // read pointer and underrun counter.
  always_comb begin
    k_d      = (state_q == FETCH) ? k_q + 2'd1 : 2'd0;
    addr_d   = (state_q == FETCH) ? fetch_addr : addr_q;
    frame_d  = frame_q;
    // Read data lags the address by one cycle: offset k returns byte k-1,
    // and the CAPTURE cycle returns byte 3.
    if (state_q == FETCH && k_q != 2'd0) begin
      frame_d[{k_q - 2'd1, 3'b000} +: 8] = bus.mem_readdata;
    end else if (state_q == CAPTURE) begin
      frame_d[31:24] = bus.mem_readdata;
    end

    if (flush_i) begin
      rd_ptr_d = wr_ptr_i;
    end else if (accept) begin
      rd_ptr_d = rd_ptr_q + (ADDR_W+1)'(4);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    ucnt_d = ucnt_q;
    if (starved && (ucnt_q != {CNT_W{1'b1}})) begin
      ucnt_d = ucnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_q      <= 2'd0;
      addr_q   <= '0;
      frame_q  <= '0;
      rd_ptr_q <= '0;
      ucnt_q   <= '0;
    end else begin
      k_q      <= k_d;
      addr_q   <= addr_d;
      frame_q  <= frame_d;
      rd_ptr_q <= rd_ptr_d;
      ucnt_q   <= ucnt_d;
    end
  end

  assign bus.mem_write     = 1'b0;
  assign bus.mem_writedata = 8'h00;
  assign bus.frame_data    = frame_q;
  assign bus.frame_valid   = frame_valid;

  assign rd_ptr_o         = rd_ptr_q;
  assign fill_level_o     = fill;
  assign underrun_o       = starved;
  assign underrun_count_o = ucnt_q;

endmodule

// File: doc/audio_ram_reader.md
Name: audio_ram_reader

Overview:
- Playback consumer on the second port of the 16 KiB, 8-bit dual-port audio RAM; the CPU fills the RAM through the first port as a byte ring buffer.
- Fetches four consecutive bytes per stereo frame through the RAM's address-registered, unregistered-output port (1-cycle read latency).
- Assembles each 16-bit little-endian left/right PCM frame and presents it to the downstream codec serializer over a valid/ready handshake.
- Exports read pointer, fill level and underrun statistics to the CPU.

Parameters:
- ADDR_W, 14, RAM byte address width; ring depth = 2**ADDR_W bytes.
- CNT_W, 16, width of the saturating underrun counter.

Ports:
- clk  in  1  system clock; the RAM port shares it.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  playback enable from the CPU control register.
- flush  in  1  single-cycle pulse; discards buffered data.
- wr_ptr  in  ADDR_W+1  CPU byte write pointer; top bit is the wrap bit.
- rd_ptr  out  ADDR_W+1  byte read pointer of the last accepted frame; top bit is the wrap bit.
- fill_level  out  ADDR_W+1  wr_ptr - rd_ptr, modulo 2**(ADDR_W+1).
- mem_address  out  ADDR_W  RAM port-2 address.
- mem_chipselect  out  1  RAM port-2 chipselect.
- mem_clken  out  1  RAM port-2 clock enable; low stalls the address register.
- mem_write  out  1  RAM port-2 write; constant 0.
- mem_writedata  out  8  constant 0.
- mem_readdata  in  8  RAM port-2 read data, valid the cycle after the address is issued.
- frame_data  out  32  [15:0] = left, [31:16] = right, signed PCM.
- frame_valid  out  1  frame_data is valid.
- frame_ready  in  1  codec accepts the frame.
- underrun  out  1  1-cycle pulse on a starved request.
- underrun_count  out  CNT_W  saturating count of starved requests.

Behaviour:
Reset values (asynchronous on reset_n low): all registered outputs 0, state IDLE, byte offset 0.

State IDLE:
- Go to FETCH when enable=1, frame_valid=0 and fill_level >= 4. Byte offset is cleared to 0.
- Otherwise stay in IDLE.

State FETCH (4 cycles, offset k = 0..3):
- mem_address = rd_ptr[ADDR_W-1:0] + k, wrapping modulo the RAM depth.
- mem_chipselect = 1, mem_clken = 1.
- The byte returned for offset k-1 is captured in the same cycle.
- After k=3, go to CAPTURE.

State CAPTURE (1 cycle):
- Capture byte 3.
- mem_chipselect = 0, mem_clken = 0.
- Go to HOLD.

State HOLD:
- frame_valid = 1; frame_data = {b3,b2,b1,b0}, i.e. left = {b1,b0}, right = {b3,b2}.
- frame_data is stable while frame_valid=1 and frame_ready=0.
- On frame_valid & frame_ready: rd_ptr += 4 (modulo 2**(ADDR_W+1)), frame_valid drops next cycle, return to IDLE.
- Latency from IDLE exit to frame_valid = 5 cycles. Minimum frame period = 7 cycles.

Outside FETCH: mem_chipselect = 0, mem_clken = 0, mem_address holds its last value.

rd_ptr advances only on acceptance, so fill_level never counts a fetched-but-unconsumed frame as free space.

Underrun:
- Asserted in any cycle where enable=1, frame_ready=1, frame_valid=0 and fill_level < 4.
- underrun pulses for that cycle; underrun_count increments and saturates at all-ones.
- No data is fabricated; the codec supplies silence.

Enable deasserted:
- In FETCH, CAPTURE or HOLD: the in-progress frame completes and is presented normally.
- No new FETCH starts.

Flush (highest priority over every other event, including a same-cycle accept):
- Next cycle: rd_ptr = wr_ptr, state IDLE, frame_valid = 0, mem_chipselect = 0, mem_clken = 0.
- underrun_count is unchanged.

Boundary conditions:
- wr_ptr is sampled every cycle; fill_level is combinational from the registered rd_ptr.
- fill_level = 2**ADDR_W means the ring is full; fill_level > 2**ADDR_W is CPU error with undefined data.
- wr_ptr that is not a multiple of 4: the trailing 1-3 bytes wait until the pointer completes the frame.
- Read-during-write on the same address is avoided by the CPU, because the mixed-port read-during-write result is don't-care.

Test Plan:
- Write bytes 0x01..0x08 to RAM, wr_ptr=8, enable=1, frame_ready=1: frames 0x04030201 then 0x08070605; first frame_valid 5 cycles after IDLE exit; rd_ptr=8; fill_level=0.
- Wrap-around with rd_ptr=0x3FFE, wr_ptr=0x4002, bytes AA,BB,CC,DD: mem_address sequence 3FFE, 3FFF, 0000, 0001; frame_data=0xDDCCBBAA; rd_ptr=0x4002.
- Backpressure: frame_ready=0 for 20 cycles in HOLD -> frame_data stable, rd_ptr unchanged, mem_chipselect=0; one frame accepted on the ready cycle.
- Underrun: wr_ptr=rd_ptr, enable=1, frame_ready held 1 for 3 cycles -> three underrun pulses, underrun_count=3. Preload count to 0xFFFF with one more starved cycle -> count stays 0xFFFF.
- Flush asserted during FETCH k=2 with wr_ptr=0x0100 -> next cycle state IDLE, rd_ptr=0x0100, frame_valid never rises, fill_level=0.
- reset_n pulsed low mid-HOLD -> frame_valid, rd_ptr, underrun_count and mem_chipselect go 0 immediately, without waiting for a clk edge.
